// File: rtl/mips_alu_mc.sv
// Multi-cycle MIPS execute unit: registered single-cycle ALU ops plus iterative
// mult/multu/div/divu into HI/LO, with a start/busy/done handshake.
module mips_alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [CNT_W-2:0] shamt,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             ovf,
    output logic             div0,
    output logic             busy,
    output logic             done
);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_NOR  = 5'd4;
    localparam logic [4:0] OP_SLT  = 5'd5;
    localparam logic [4:0] OP_SLTU = 5'd6;
    localparam logic [4:0] OP_SLL  = 5'd7;
    localparam logic [4:0] OP_SRL  = 5'd8;
    localparam logic [4:0] OP_SRA  = 5'd9;
    localparam logic [4:0] OP_LUI  = 5'd10;
    localparam logic [4:0] OP_MFHI = 5'd11;
    localparam logic [4:0] OP_MFLO = 5'd12;
    localparam logic [4:0] OP_MULT = 5'd13;
    localparam logic [4:0] OP_MULTU = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_DIVU = 5'd16;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     a_raw;
    logic                 neg_res;
    logic                 neg_rem;

    logic [WIDTH-1:0]     add_sum, sub_diff, lui_val, sc_result;
    logic                 add_ovf, sub_ovf, sc_ovf;
    logic                 is_mul_op, is_div_op, signed_op, last_iter;
    logic [WIDTH-1:0]     a_mag_in, b_mag_in;
    logic [WIDTH:0]       mul_sum, div_trial;
    logic [2*WIDTH-1:0]   acc_step, prod_final;
    logic                 div_ge;
    logic [WIDTH-1:0]     rem_step, quo_step, rem_final, quo_final;

    assign is_mul_op = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
    assign is_div_op = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
    assign signed_op = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state != IDLE);

    assign add_sum  = rs_val + rt_val;
    assign sub_diff = rs_val - rt_val;
    assign add_ovf  = (rs_val[WIDTH-1] == rt_val[WIDTH-1]) && (add_sum[WIDTH-1] != rs_val[WIDTH-1]);
    assign sub_ovf  = (rs_val[WIDTH-1] != rt_val[WIDTH-1]) && (sub_diff[WIDTH-1] != rs_val[WIDTH-1]);

    generate
        if (WIDTH >= 32) begin : g_lui_wide
            assign lui_val = {{(WIDTH-16){1'b0}}, rt_val[15:0]} << 16;
        end else begin : g_lui_narrow
            assign lui_val = rt_val << (WIDTH / 2);
        end
    endgenerate

    always_comb begin
        sc_result = add_sum;
        sc_ovf    = 1'b0;
        case (alu_op)
            OP_ADD:  begin sc_result = add_sum;  sc_ovf = add_ovf; end
            OP_SUB:  begin sc_result = sub_diff; sc_ovf = sub_ovf; end
            OP_AND:  sc_result = rs_val & rt_val;
            OP_OR:   sc_result = rs_val | rt_val;
            OP_NOR:  sc_result = ~(rs_val | rt_val);
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(rs_val) < $signed(rt_val))};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (rs_val < rt_val)};
            OP_SLL:  sc_result = rt_val << shamt;
            OP_SRL:  sc_result = rt_val >> shamt;
            OP_SRA:  sc_result = $unsigned($signed(rt_val) >>> shamt);
            OP_LUI:  sc_result = lui_val;
            OP_MFHI: sc_result = hi;
            OP_MFLO: sc_result = lo;
            default: sc_result = add_sum;
        endcase
    end

    assign a_mag_in = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign b_mag_in = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
    assign acc_step   = {mul_sum, acc[WIDTH-1:1]};
    assign prod_final = neg_res ? -acc_step : acc_step;

    // Divide: acc holds {partial remainder, dividend/quotient shift register}.
    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, b_mag};
    assign div_ge    = ~div_trial[WIDTH];
    assign rem_step  = div_ge ? div_trial[WIDTH-1:0] : {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
    assign quo_step  = {acc[WIDTH-2:0], div_ge};
    assign quo_final = neg_res ? -quo_step : quo_step;
    assign rem_final = neg_rem ? -rem_step : rem_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && is_mul_op) begin
                    state_next = MUL;
                end else if (start && is_div_op) begin
                    state_next = DIV;
                end
            end
            MUL, DIV: begin
                if (last_iter) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result  <= '0;
            hi      <= '0;
            lo      <= '0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            div0    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            b_mag   <= '0;
            a_raw   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (is_mul_op || is_div_op)) begin
                        acc     <= {{WIDTH{1'b0}}, a_mag_in};
                        b_mag   <= b_mag_in;
                        a_raw   <= rs_val;
                        neg_res <= signed_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        neg_rem <= signed_op && rs_val[WIDTH-1];
                        cnt     <= '0;
                    end else if (start) begin
                        result <= sc_result;
                        zero   <= (sc_result == '0);
                        ovf    <= sc_ovf;
                        done   <= 1'b1;
                    end
                end
                MUL: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        hi   <= prod_final[2*WIDTH-1:WIDTH];
                        lo   <= prod_final[WIDTH-1:0];
                        done <= 1'b1;
                    end
                end
                DIV: begin
                    acc <= {rem_step, quo_step};
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        div0 <= (b_mag == '0);
                        done <= 1'b1;
                        if (b_mag == '0) begin
                            lo <= '1;
                            hi <= a_raw;
                        end else begin
                            lo <= quo_final;
                            hi <= rem_final;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_mc.sv
// Self-checking bench for mips_alu_mc: arithmetic reference model compared every
// cycle (WIDTH=32) plus directed literal checks, including a WIDTH=8 build.
module tb_mips_alu_mc;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [4:0]  alu_op, shamt;
    logic [31:0] rs_val, rt_val, result, hi, lo;
    logic        zero, ovf, div0, busy, done;

    logic        start8;
    logic [4:0]  alu_op8;
    logic [2:0]  shamt8;
    logic [7:0]  rs8, rt8, result8, hi8, lo8;
    logic        zero8, ovf8, div08, busy8, done8;

    int checks = 0;
    int errors = 0;

    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -MAX_S - 1;

    always #5 clk = ~clk;

    mips_alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_op(alu_op),
        .rs_val(rs_val), .rt_val(rt_val), .shamt(shamt),
        .result(result), .hi(hi), .lo(lo), .zero(zero), .ovf(ovf),
        .div0(div0), .busy(busy), .done(done)
    );

    mips_alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .alu_op(alu_op8),
        .rs_val(rs8), .rt_val(rt8), .shamt(shamt8),
        .result(result8), .hi(hi8), .lo(lo8), .zero(zero8), .ovf(ovf8),
        .div0(div08), .busy(busy8), .done(done8)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Reference for single-cycle ops; returns {zero, ovf, result}.
    function automatic logic [33:0] modelShort(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                               input logic [4:0] sh, input logic [31:0] h, input logic [31:0] l);
        longint      sa, sb, s;
        logic [31:0] r;
        logic        v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = a + b;
        v  = 1'b0;
        case (op)
            5'd0:  begin s = sa + sb; r = 32'(s); v = (s > MAX_S) || (s < MIN_S); end
            5'd1:  begin s = sa - sb; r = 32'(s); v = (s > MAX_S) || (s < MIN_S); end
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = ~(a | b);
            5'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd6:  r = (a < b) ? 32'd1 : 32'd0;
            5'd7:  r = b << sh;
            5'd8:  r = b >> sh;
            5'd9:  r = 32'($signed(b) >>> sh);
            5'd10: r = {b[15:0], 16'h0000};
            5'd11: r = h;
            5'd12: r = l;
            default: r = a + b;
        endcase
        return {(r == 32'd0), v, r};
    endfunction

    // Reference for mult/div; returns {div0, hi, lo}.
    function automatic logic [64:0] modelLong(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [64:0] res;
        case (op)
            5'd13: begin
                p   = 64'(longint'($signed(a)) * longint'($signed(b)));
                res = {1'b0, p};
            end
            5'd14: begin
                p   = {32'd0, a} * {32'd0, b};
                res = {1'b0, p};
            end
            default: begin
                if (b == 32'd0)
                    res = {1'b1, a, 32'hFFFF_FFFF};
                else if (op == 5'd16)
                    res = {1'b0, a % b, a / b};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    res = {1'b0, 32'd0, 32'h8000_0000};
                else
                    res = {1'b0, 32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            end
        endcase
        return res;
    endfunction

    logic [33:0] m_short;
    logic [64:0] m_pend;
    logic [31:0] m_hi, m_lo;
    logic        m_div0, m_busy, m_done, m_pend_div, m_valid = 1'b0;
    int          m_left;

    always @(posedge clk) begin
        if (reset) begin
            m_short <= '0; m_hi <= '0; m_lo <= '0; m_div0 <= 1'b0;
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_valid <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    if (m_pend_div) m_div0 <= m_pend[64];
                end
            end else if (start) begin
                if (alu_op >= 5'd13 && alu_op <= 5'd16) begin
                    m_pend     <= modelLong(alu_op, rs_val, rt_val);
                    m_pend_div <= (alu_op >= 5'd15);
                    m_busy     <= 1'b1;
                    m_left     <= 32;
                end else begin
                    m_short <= modelShort(alu_op, rs_val, rt_val, shamt, m_hi, m_lo);
                    m_done  <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("cyc_result", result, m_short[31:0]);
            checkOutput("cyc_ovf", 32'(ovf), 32'(m_short[32]));
            checkOutput("cyc_zero", 32'(zero), 32'(m_short[33]));
            checkOutput("cyc_hi", hi, m_hi);
            checkOutput("cyc_lo", lo, m_lo);
            checkOutput("cyc_div0", 32'(div0), 32'(m_div0));
            checkOutput("cyc_busy", 32'(busy), 32'(m_busy));
            checkOutput("cyc_done", 32'(done), 32'(m_done));
        end
    end

    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        @(negedge clk);
        start  = 1'b1;
        alu_op = op;
        rs_val = a;
        rt_val = b;
        shamt  = sh;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic runSingle(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] sh, input logic [31:0] exp_res, input logic exp_ovf);
        applyStimulus(op, a, b, sh);
        checkOutput({name, "_result"}, result, exp_res);
        checkOutput({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        checkOutput({name, "_zero"}, 32'(zero), (exp_res == 32'd0) ? 32'd1 : 32'd0);
        checkOutput({name, "_done"}, 32'(done), 32'd1);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic waitDone(input string name, input int exp_busy);
        int n = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) n++;
            @(negedge clk);
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({name, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    endtask

    task automatic runLong(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_d0);
        applyStimulus(op, a, b, 5'd0);
        waitDone(name, 32);
        checkOutput({name, "_hi"}, hi, exp_hi);
        checkOutput({name, "_lo"}, lo, exp_lo);
        checkOutput({name, "_div0"}, 32'(div0), 32'(exp_d0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n8;
        bit  seen8;
        reset = 1'b1; start = 1'b0; alu_op = '0; rs_val = '0; rt_val = '0; shamt = '0;
        start8 = 1'b0; alu_op8 = '0; rs8 = '0; rt8 = '0; shamt8 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_div0", 32'(div0), 32'd0);

        runSingle("add_ovf",  5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b1);
        runSingle("sub_zero", 5'd1,  32'd5,         32'd5,         5'd0,  32'h0000_0000, 1'b0);
        runSingle("sub_ovf",  5'd1,  32'h8000_0000, 32'd1,         5'd0,  32'h7FFF_FFFF, 1'b1);
        runSingle("and",      5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 1'b0);
        runSingle("or",       5'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hFFF0_FFF0, 1'b0);
        runSingle("nor",      5'd4,  32'd0,         32'd0,         5'd0,  32'hFFFF_FFFF, 1'b0);
        runSingle("slt",      5'd5,  32'hFFFF_FFFF, 32'd1,         5'd0,  32'd1,         1'b0);
        runSingle("sltu",     5'd6,  32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0,         1'b0);
        runSingle("sll",      5'd7,  32'd0,         32'd1,         5'd31, 32'h8000_0000, 1'b0);
        runSingle("srl",      5'd8,  32'd0,         32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0);
        runSingle("sra",      5'd9,  32'd0,         32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0);
        runSingle("lui",      5'd10, 32'h1234_5678, 32'h5555_ABCD, 5'd0,  32'hABCD_0000, 1'b0);
        runSingle("illegal",  5'd20, 32'h7FFF_FFFF, 32'd1,         5'd0,  32'h8000_0000, 1'b0);

        runLong("mult_neg", 5'd13, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        runSingle("mfhi", 5'd11, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
        runSingle("mflo", 5'd12, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFEB, 1'b0);
        runLong("div_pos_neg", 5'd15, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0);
        runLong("div_neg_pos", 5'd15, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
        runLong("divu_big", 5'd16, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
        runLong("div_minneg", 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        runLong("divu_zero", 5'd16, 32'd55, 32'd0, 32'd55, 32'hFFFF_FFFF, 1'b1);
        runLong("div_clear", 5'd15, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

        applyStimulus(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        repeat (3) @(negedge clk);
        applyStimulus(5'd0, 32'd1, 32'd2, 5'd0);
        waitDone("multu_ignore", 27);
        checkOutput("multu_ignore_hi", hi, 32'hFFFF_FFFE);
        checkOutput("multu_ignore_lo", lo, 32'h0000_0001);
        checkOutput("multu_ignore_result", result, 32'hFFFF_FFEB);

        applyStimulus(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("abort_done_after", 32'(done), 32'd0);

        @(negedge clk);
        start8 = 1'b1; alu_op8 = 5'd9; rt8 = 8'h80; shamt8 = 3'd3;
        @(negedge clk);
        start8 = 1'b0;
        checkOutput("w8_sra_result", 32'(result8), 32'h0000_00F0);
        checkOutput("w8_sra_done", 32'(done8), 32'd1);

        @(negedge clk);
        start8 = 1'b1; alu_op8 = 5'd13; rs8 = 8'h80; rt8 = 8'h80;
        @(negedge clk);
        start8 = 1'b0;
        n8 = 0;
        seen8 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done8) begin
                seen8 = 1'b1;
                break;
            end
            if (busy8) n8++;
            @(negedge clk);
        end
        checkOutput("w8_mult_done_seen", 32'(seen8), 32'd1);
        checkOutput("w8_mult_busy_cycles", 32'(n8), 32'd8);
        checkOutput("w8_mult_hi", 32'(hi8), 32'h0000_0040);
        checkOutput("w8_mult_lo", 32'(lo8), 32'h0000_0000);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
